// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and data access, one transaction at a time.
// Data wins arbitration unless a waiting fetch has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                inst_req_valid,
  output logic                inst_req_ready,
  input  logic [ADDR_W-1:0]   inst_paddr,
  input  logic                inst_uncached,
  output logic                inst_resp_valid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req_valid,
  output logic                data_req_ready,
  input  logic [ADDR_W-1:0]   data_paddr,
  input  logic                data_uncached,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_resp_valid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_uncached,
  output logic                bus_owner,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [1:0]          state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                drop_q, drop_d;
  logic                req_valid_q, req_valid_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                unc_q, unc_d;

  logic in_idle, in_resp, grant_data, grant_inst;

  assign in_idle    = (state_q == S_IDLE);
  assign in_resp    = (state_q == S_RESP);
  assign grant_data = in_idle && data_req_valid && !(inst_req_valid && (starve_q == LIMIT));
  assign grant_inst = in_idle && !grant_data && inst_req_valid && !flush;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign inst_req_ready  = reset && grant_inst;
  assign data_req_ready  = reset && grant_data;
  assign inst_resp_valid = in_resp && !owner_q && bus_resp_valid && !drop_q && !flush;
  assign data_resp_valid = in_resp && owner_q && bus_resp_valid;
  assign inst_rdata      = (in_resp && !owner_q) ? bus_rdata : '0;
  assign data_rdata      = (in_resp && owner_q) ? bus_rdata : '0;

  assign bus_req_valid = req_valid_q;
  assign bus_addr      = addr_q;
  assign bus_we        = we_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;
  assign bus_uncached  = unc_q;
  assign bus_owner     = owner_q;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    req_valid_d = req_valid_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    unc_d       = unc_q;
    case (state_q)
      S_IDLE: begin
        if (grant_inst || !inst_req_valid) begin
          starve_d = '0;
        end else if (grant_data && (starve_q != 4'hF)) begin
          starve_d = starve_q + 4'd1;
        end
        if (grant_data) begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          owner_d     = 1'b1;
          addr_d      = data_paddr;
          we_d        = data_we;
          wstrb_d     = data_wstrb;
          wdata_d     = data_wdata;
          unc_d       = data_uncached;
        end else if (grant_inst) begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          owner_d     = 1'b0;
          addr_d      = inst_paddr;
          we_d        = 1'b0;
          wstrb_d     = '0;
          wdata_d     = '0;
          unc_d       = inst_uncached;
        end
      end
      S_REQ: begin
        if (!owner_q && flush) drop_d = 1'b1;
        if (bus_req_ready) begin
          state_d     = S_RESP;
          req_valid_d = 1'b0;
        end
      end
      S_RESP: begin
        // A flush coinciding with the response is covered by the !flush term on inst_resp_valid.
        if (bus_resp_valid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end else if (!owner_q && flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      unc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      unc_q       <= unc_d;
    end
  end

endmodule
